// File: rtl/snn_aer_pkg.sv
// Shared AER definitions for the rank-order sorter/encoder and decoder.
// Contents:
//   - the decoder state encoding
//   - the helper that builds the two-event reset preamble code
package snn_aer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } rank_dec_state_t;

  // Reset code is 2'b01 followed by 'width' ones, e.g. 0x1FF for width 8
  function automatic logic [31:0] aer_reset_code(input int unsigned width);
    return (32'd2 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/rank_image_buffer.sv
// Pixel register array for the rank-order decoder.
// Holds one intensity word per pixel.
// Optional RANK_DEC_DUP_CHECK_EN adds a per-pixel seen bitmap; the bitmap is
// looked up at the write address so the caller can reject repeated indices.
module rank_image_buffer
  import snn_aer_pkg::*;
#(
  parameter int IMAGE_SIZE = 256,
  parameter int ADDR_BITS  = $clog2(IMAGE_SIZE),
  parameter int PIXEL_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [PIXEL_BITS:0]   wr_data,
`ifdef RANK_DEC_DUP_CHECK_EN
  output logic                  seen_hit,
`endif
  output logic [PIXEL_BITS:0]   pixels [IMAGE_SIZE]
);

  // Pixel words: cleared together, written one at a time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMAGE_SIZE; i++) pixels[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < IMAGE_SIZE; i++) pixels[i] <= '0;
    end else if (wr_en) begin
      pixels[wr_addr] <= wr_data;
    end
  end

`ifdef RANK_DEC_DUP_CHECK_EN
  logic [IMAGE_SIZE-1:0] seen;

  // Seen bitmap marks every pixel that has already received its rank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen <= '0;
    end else if (clear) begin
      seen <= '0;
    end else if (wr_en) begin
      seen[wr_addr] <= 1'b1;
    end
  end

  assign seen_hit = seen[wr_addr];
`endif

endmodule

// File: rtl/rank_order_decoder.sv
// Rank-order AER decoder: strips the two-event reset preamble, converts
// arrival rank into intensity (earliest = brightest) and rebuilds the image.
// Optional feature macro: RANK_DEC_DUP_CHECK_EN (reject repeated indices,
// adds sticky dup_err output).
module rank_order_decoder
  import snn_aer_pkg::*;
#(
  parameter int IMAGE_SIZE      = 256,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int PIXEL_MAX_VALUE = 255,
  parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE),
  parameter int BUSY_CYCLES     = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        abort,
  input  logic                        event_valid,
  input  logic [IMAGE_SIZE_BITS+1:0]  event_index,
  output logic                        busy,
  output logic [PIXEL_BITS:0]         image_out [IMAGE_SIZE],
  output logic                        image_valid,
  output logic [IMAGE_SIZE_BITS:0]    rank_count,
  output logic                        sync_err,
  output logic                        range_err,
`ifdef RANK_DEC_DUP_CHECK_EN
  output logic                        dup_err,
`endif
  output logic                        overrun_err
);

  localparam int IDX_W = IMAGE_SIZE_BITS + 2;
  localparam int RC_W  = IMAGE_SIZE_BITS + 1;
  localparam int PW    = PIXEL_BITS + 1;
  localparam int BC_W  = $clog2(BUSY_CYCLES + 1);

  localparam logic [IDX_W-1:0] RESET_CODE = IDX_W'(aer_reset_code(IMAGE_SIZE_BITS));
  localparam logic [IDX_W-1:0] SIZE_IDX   = IDX_W'(IMAGE_SIZE);
  localparam logic [RC_W-1:0]  FULL_RANK  = RC_W'(IMAGE_SIZE);
  localparam logic [BC_W-1:0]  BUSY_LOAD  = BC_W'(BUSY_CYCLES);
  localparam logic [31:0]      MAX_U      = 32'(PIXEL_MAX_VALUE);

  rank_dec_state_t state, next_state;

  logic [BC_W-1:0] busy_cnt, busy_cnt_next;
  logic            busy_next;
  logic            pre_cnt;
  logic            in_stream, abort_act, accept;
  logic            is_code, in_range, dup_hit;
  logic            code_sync, code_recv, pix_write, buf_clear;
  logic            overrun_hit, sync_hit, range_hit;
  logic [31:0]     rank_ext;
  logic [PW-1:0]   wr_data;
`ifdef RANK_DEC_DUP_CHECK_EN
  logic            seen_hit;
`endif

  // Event decode: CLEAR beats ABORT, both beat an event in the same cycle
  always_comb begin
    in_stream   = (state == SYNC) || (state == RECV);
    abort_act   = abort && in_stream;
    accept      = event_valid && !busy && in_stream && !clear && !abort_act;
    is_code     = (event_index == RESET_CODE);
    in_range    = (event_index < SIZE_IDX);
`ifdef RANK_DEC_DUP_CHECK_EN
    dup_hit     = accept && (state == RECV) && !is_code && in_range && seen_hit;
`else
    dup_hit     = 1'b0;
`endif
    code_sync   = accept && (state == SYNC) && is_code;
    code_recv   = accept && (state == RECV) && is_code;
    pix_write   = accept && (state == RECV) && !is_code && in_range && !dup_hit;
    buf_clear   = clear || code_recv;
    overrun_hit = event_valid && busy && in_stream && !clear && !abort_act;
    sync_hit    = accept && (state == SYNC) && !is_code;
    range_hit   = accept && (state == RECV) && !is_code && !in_range;
    rank_ext    = 32'(rank_count);
    wr_data     = (rank_ext >= MAX_U) ? '0 : PW'(MAX_U - rank_ext);
  end

  // Busy hold counter reloads on each accept and drains to zero
  always_comb begin
    busy_cnt_next = busy_cnt;
    if (clear) begin
      busy_cnt_next = '0;
    end else if (accept) begin
      busy_cnt_next = BUSY_LOAD;
    end else if (busy_cnt != '0) begin
      busy_cnt_next = busy_cnt - 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = SYNC;
    end else begin
      case (state)
        IDLE: next_state = IDLE;
        SYNC: begin
          if (abort_act)                 next_state = DONE;
          else if (code_sync && pre_cnt) next_state = RECV;
        end
        RECV: begin
          if (abort_act)                    next_state = DONE;
          else if (rank_count == FULL_RANK) next_state = DONE;
          else if (code_recv)               next_state = SYNC;
        end
        DONE:    next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs: image valid in DONE; busy outside the stream states or while holding
  always_comb begin
    image_valid = (state == DONE);
    busy_next   = (next_state == IDLE) || (next_state == DONE) || (busy_cnt_next != '0);
  end

  // Counters, preamble tracking and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt    <= '0;
      busy        <= 1'b0;
      rank_count  <= '0;
      pre_cnt     <= 1'b0;
      sync_err    <= 1'b0;
      range_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef RANK_DEC_DUP_CHECK_EN
      dup_err     <= 1'b0;
`endif
    end else begin
      busy_cnt <= busy_cnt_next;
      busy     <= busy_next;
      if (clear) begin
        rank_count  <= '0;
        pre_cnt     <= 1'b0;
        sync_err    <= 1'b0;
        range_err   <= 1'b0;
        overrun_err <= 1'b0;
`ifdef RANK_DEC_DUP_CHECK_EN
        dup_err     <= 1'b0;
`endif
      end else begin
        if (overrun_hit) overrun_err <= 1'b1;
        if (range_hit)   range_err   <= 1'b1;
`ifdef RANK_DEC_DUP_CHECK_EN
        if (dup_hit)     dup_err     <= 1'b1;
`endif
        if (sync_hit) begin
          sync_err <= 1'b1;
          pre_cnt  <= 1'b0;
        end
        // Second code of the preamble drops the count back to 0 on entering RECV
        if (code_sync) pre_cnt <= ~pre_cnt;
        // A code mid-image restarts the image and counts as the first preamble event
        if (code_recv) begin
          rank_count <= '0;
          pre_cnt    <= 1'b1;
        end
        if (pix_write) rank_count <= rank_count + 1'b1;
      end
    end
  end

  rank_image_buffer #(
    .IMAGE_SIZE (IMAGE_SIZE),
    .ADDR_BITS  (IMAGE_SIZE_BITS),
    .PIXEL_BITS (PIXEL_BITS)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (buf_clear),
    .wr_en    (pix_write),
    .wr_addr  (event_index[IMAGE_SIZE_BITS-1:0]),
    .wr_data  (wr_data),
`ifdef RANK_DEC_DUP_CHECK_EN
    .seen_hit (seen_hit),
`endif
    .pixels   (image_out)
  );

endmodule

// File: tb/tb_rank_order_decoder.sv
// Directed bench for rank_order_decoder: a default-sized instance (256 pixels,
// BUSY_CYCLES=1) and a small one (4 pixels, max 3, BUSY_CYCLES=2).
// Honors RANK_DEC_DUP_CHECK_EN for the repeated-index expectations.
module tb_rank_order_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-size instance
  logic       clear, abort, ev_valid;
  logic [9:0] ev_index;
  logic       busy, image_valid, sync_err, range_err, overrun_err;
  logic [8:0] rank_count;
  logic [8:0] image_out [256];
`ifdef RANK_DEC_DUP_CHECK_EN
  logic       dup_err;
`endif

  // Small instance
  logic       s_clear, s_abort, s_valid;
  logic [3:0] s_index;
  logic       s_busy, s_image_valid, s_sync_err, s_range_err, s_overrun_err;
  logic [2:0] s_rank;
  logic [2:0] s_image [4];
`ifdef RANK_DEC_DUP_CHECK_EN
  logic       s_dup_err;
`endif

  int total = 0;
  int bad   = 0;
  int rc    = 0;

  rank_order_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .abort       (abort),
    .event_valid (ev_valid),
    .event_index (ev_index),
    .busy        (busy),
    .image_out   (image_out),
    .image_valid (image_valid),
    .rank_count  (rank_count),
    .sync_err    (sync_err),
    .range_err   (range_err),
`ifdef RANK_DEC_DUP_CHECK_EN
    .dup_err     (dup_err),
`endif
    .overrun_err (overrun_err)
  );

  rank_order_decoder #(
    .IMAGE_SIZE      (4),
    .PIXEL_MAX_VALUE (3),
    .BUSY_CYCLES     (2)
  ) dut_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (s_clear),
    .abort       (s_abort),
    .event_valid (s_valid),
    .event_index (s_index),
    .busy        (s_busy),
    .image_out   (s_image),
    .image_valid (s_image_valid),
    .rank_count  (s_rank),
    .sync_err    (s_sync_err),
    .range_err   (s_range_err),
`ifdef RANK_DEC_DUP_CHECK_EN
    .dup_err     (s_dup_err),
`endif
    .overrun_err (s_overrun_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One event, then one hold cycle (BUSY_CYCLES=1)
  task automatic send(input logic [9:0] idx);
    ev_index = idx;
    ev_valid = 1'b1;
    tick();
    ev_valid = 1'b0;
    tick();
  endtask

  // One event on the small instance, then two hold cycles (BUSY_CYCLES=2)
  task automatic s_send(input logic [3:0] idx);
    s_index = idx;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
  endtask

  function automatic logic [9:0] perm(input int k);
    return 10'((k * 37 + 11) % 256);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 0; abort = 0; ev_valid = 0; ev_index = '0;
    s_clear = 0; s_abort = 0; s_valid = 0; s_index = '0;

    // Reset values
    #23;
    check("rst_busy", 32'(busy), 0);
    check("rst_image_valid", 32'(image_valid), 0);
    check("rst_rank", 32'(rank_count), 0);
    check("rst_errs", 32'({sync_err, range_err, overrun_err}), 0);
    check("rst_pix0", 32'(image_out[0]), 0);
    check("rst_s_busy", 32'(s_busy), 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 1);
    check("idle_image_valid", 32'(image_valid), 0);

    // Events in IDLE are ignored silently
    send(10'd5);
    check("idle_no_overrun", 32'(overrun_err), 0);
    check("idle_rank", 32'(rank_count), 0);

    // Pixel before preamble
    clear = 1; tick(); clear = 0;
    check("sync_busy_low", 32'(busy), 0);
    send(10'd10);
    check("sync_err_set", 32'(sync_err), 1);
    check("sync_rank", 32'(rank_count), 0);
    check("sync_pix10", 32'(image_out[10]), 0);
    send(10'h1FF);
    send(10'h1FF);
    send(10'd4);
    check("first_pix4", 32'(image_out[4]), 255);
    check("first_rank", 32'(rank_count), 1);
    check("sync_err_sticky", 32'(sync_err), 1);

    // Repeated index
    send(10'd4);
`ifdef RANK_DEC_DUP_CHECK_EN
    rc = 1;
    check("dup_err", 32'(dup_err), 1);
    check("dup_rank", 32'(rank_count), 1);
    check("dup_pix4", 32'(image_out[4]), 255);
`else
    rc = 2;
    check("rep_rank", 32'(rank_count), 2);
    check("rep_pix4", 32'(image_out[4]), 254);
`endif

    // Back-to-back pulses: second one dropped
    ev_index = 10'd6; ev_valid = 1;
    tick();
    check("ovr_busy_rise", 32'(busy), 1);
    tick();
    ev_valid = 0;
    check("ovr_err", 32'(overrun_err), 1);
    check("ovr_rank", 32'(rank_count), 32'(rc + 1));
    check("ovr_pix6", 32'(image_out[6]), 32'(255 - rc));
    tick();

    // Out-of-range index, then a mid-image reset code
    send(10'd300);
    check("range_err", 32'(range_err), 1);
    check("range_rank", 32'(rank_count), 32'(rc + 1));
    check("range_pix44", 32'(image_out[44]), 0);
    send(10'h1FF);
    check("midcode_rank", 32'(rank_count), 0);
    check("midcode_pix4", 32'(image_out[4]), 0);
    check("midcode_pix6", 32'(image_out[6]), 0);
    send(10'h1FF);
    send(10'd9);
    check("resync_pix9", 32'(image_out[9]), 255);
    check("resync_rank", 32'(rank_count), 1);

    // Abort -> DONE next cycle, unwritten pixels stay 0
    abort = 1; tick(); abort = 0;
    check("abort_valid", 32'(image_valid), 1);
    check("abort_busy", 32'(busy), 1);
    check("abort_pix9", 32'(image_out[9]), 255);
    check("abort_pix5", 32'(image_out[5]), 0);

    // CLEAR beats ABORT
    clear = 1; abort = 1; tick(); clear = 0; abort = 0;
    check("clr_valid", 32'(image_valid), 0);
    check("clr_errs", 32'({sync_err, range_err, overrun_err}), 0);
    check("clr_pix9", 32'(image_out[9]), 0);
    check("clr_rank", 32'(rank_count), 0);
    check("clr_busy", 32'(busy), 0);

    // Full 256-pixel permutation
    send(10'h1FF);
    send(10'h1FF);
    for (int k = 0; k < 255; k++) send(perm(k));
    ev_index = perm(255); ev_valid = 1;
    tick();
    ev_valid = 0;
    check("full_rank", 32'(rank_count), 256);
    check("full_not_done_yet", 32'(image_valid), 0);
    tick();
    check("full_done", 32'(image_valid), 1);
    for (int k = 0; k < 256; k++)
      check($sformatf("perm_pix_k%0d", k), 32'(image_out[perm(k)]), 32'(255 - k));
    send(10'h1FF);
    check("done_silent", 32'(overrun_err), 0);
    check("done_rank_held", 32'(rank_count), 256);
    check("done_pix_held", 32'(image_out[perm(0)]), 255);

    // Small image: indices 2,0,3,1
    s_clear = 1; tick(); s_clear = 0;
    s_send(4'h7);
    s_send(4'h7);
    s_send(4'd2);
    s_send(4'd0);
    s_send(4'd3);
    s_index = 4'd1; s_valid = 1;
    tick();
    s_valid = 0;
    check("s_rank_full", 32'(s_rank), 4);
    check("s_not_done_yet", 32'(s_image_valid), 0);
    tick();
    check("s_done", 32'(s_image_valid), 1);
    check("s_pix2", 32'(s_image[2]), 3);
    check("s_pix0", 32'(s_image[0]), 2);
    check("s_pix3", 32'(s_image[3]), 1);
    check("s_pix1", 32'(s_image[1]), 0);

    // Small image overrun with a two-cycle hold
    s_clear = 1; tick(); s_clear = 0;
    s_send(4'h7);
    s_send(4'h7);
    s_index = 4'd1; s_valid = 1;
    tick();
    check("s_busy_rise", 32'(s_busy), 1);
    tick();
    s_valid = 0;
    check("s_ovr_err", 32'(s_overrun_err), 1);
    check("s_busy_hold2", 32'(s_busy), 1);
    tick();
    check("s_busy_fall", 32'(s_busy), 0);
    check("s_ovr_rank", 32'(s_rank), 1);
    check("s_ovr_pix1", 32'(s_image[1]), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
